// File: rtl/dircc_node_mem_port2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dircc_node_mem_port2_arbiter
// Purpose  : Round-robin arbiter sharing the 16-bit s2 port of a node's
//            dual-port processing memory between the inbound packet writer
//            (requester 0) and the outbound packet reader (requester 1).
//            One s2 access per cycle; read data returns one cycle after the
//            grant to the requester that issued the read.
// Options  : DIRCC_MEM_ARB_BOUNDS_EN - reject addresses >= DEPTH, flag
//            rejected reads with rerr and count rejects in err_count.
// Revision : 1.0 - initial release
// ============================================================================
module dircc_node_mem_port2_arbiter #(
    parameter int DEPTH = 10000,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          freeze,

    input  logic          req0_valid,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [15:0]   req0_wdata,
    input  logic [1:0]    req0_be,
    output logic          req0_gnt,
    output logic          req0_rvalid,
    output logic [15:0]   req0_rdata,
`ifdef DIRCC_MEM_ARB_BOUNDS_EN
    output logic          req0_rerr,
`endif

    input  logic          req1_valid,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [15:0]   req1_wdata,
    input  logic [1:0]    req1_be,
    output logic          req1_gnt,
    output logic          req1_rvalid,
    output logic [15:0]   req1_rdata,
`ifdef DIRCC_MEM_ARB_BOUNDS_EN
    output logic          req1_rerr,
`endif

    output logic          mem_chipselect2,
    output logic          mem_write2,
    output logic [AW-1:0] mem_address2,
    output logic [15:0]   mem_writedata2,
    output logic [1:0]    mem_byteenable2,
    output logic          mem_clken2,
    input  logic [15:0]   mem_readdata2,

    output logic [7:0]    err_count
);

    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic          r_prio;
    logic          r_rd_pend;
    logic          r_rd_id;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_wdata;
    logic [1:0]    r_be;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any;
    logic          w_sel_write;
    logic [AW-1:0] w_sel_addr;
    logic [15:0]   w_sel_wdata;
    logic [1:0]    w_sel_be;
    logic          w_addr_ok;
    logic          w_in_range;
    logic          w_cs;
    logic          w_rv0;
    logic          w_rv1;
    logic [15:0]   w_rdata;

    // Grant: a lone requester wins outright, under contention prio decides.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset && !freeze) begin
            w_gnt0 = req0_valid && (!req1_valid || (r_prio == 1'b0));
            w_gnt1 = req1_valid && (!req0_valid || (r_prio == 1'b1));
        end
    end

    assign w_any       = w_gnt0 | w_gnt1;
    assign w_sel_write = w_gnt1 ? req1_write : req0_write;
    assign w_sel_addr  = w_gnt1 ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_gnt1 ? req1_wdata : req0_wdata;
    assign w_sel_be    = w_gnt1 ? req1_be    : req0_be;
    assign w_addr_ok   = ({1'b0, w_sel_addr} < c_DEPTH);

`ifdef DIRCC_MEM_ARB_BOUNDS_EN
    logic       r_rd_err;
    logic [7:0] r_err_count;

    assign w_in_range = w_addr_ok;

    // Track the error flag of an issued read and count rejected accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_err    <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_rd_err <= !w_in_range;
            if (w_any && !w_in_range && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign w_rdata   = r_rd_err ? 16'd0 : mem_readdata2;
    assign req0_rerr = w_rv0 & r_rd_err;
    assign req1_rerr = w_rv1 & r_rd_err;
    assign err_count = r_err_count;
`else
    // Range check is not applied in this build; keep the compare referenced.
    logic w_unused_addr_ok;
    assign w_unused_addr_ok = w_addr_ok;
    assign w_in_range = 1'b1;
    assign w_rdata    = mem_readdata2;
    assign err_count  = 8'd0;
`endif

    assign w_cs = w_any & w_in_range;

    // Priority pointer, read-return pipeline and held memory fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio    <= 1'b0;
            r_rd_pend <= 1'b0;
            r_rd_id   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 16'd0;
            r_be      <= 2'd0;
        end else begin
            if (w_gnt0) begin
                r_prio <= 1'b1;
            end else if (w_gnt1) begin
                r_prio <= 1'b0;
            end
            r_rd_pend <= w_any && !w_sel_write;
            r_rd_id   <= w_gnt1;
            if (w_any) begin
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_be    <= w_sel_be;
            end
        end
    end

    assign req0_gnt        = w_gnt0;
    assign req1_gnt        = w_gnt1;

    // Response for a read issued last cycle; suppressed while in reset.
    assign w_rv0           = !reset && r_rd_pend && !r_rd_id;
    assign w_rv1           = !reset && r_rd_pend &&  r_rd_id;
    assign req0_rvalid     = w_rv0;
    assign req1_rvalid     = w_rv1;
    assign req0_rdata      = w_rv0 ? w_rdata : 16'd0;
    assign req1_rdata      = w_rv1 ? w_rdata : 16'd0;

    assign mem_chipselect2 = w_cs;
    assign mem_write2      = w_cs & w_sel_write;
    assign mem_address2    = w_any ? w_sel_addr  : r_addr;
    assign mem_writedata2  = w_any ? w_sel_wdata : r_wdata;
    assign mem_byteenable2 = w_any ? w_sel_be    : r_be;
    assign mem_clken2      = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_dircc_node_mem_port2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dircc_node_mem_port2_arbiter
// Purpose  : Directed bench; stimulus pushes expected read responses into a
//            queue which a separate monitor pops when rvalid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dircc_node_mem_port2_arbiter;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          freeze;
    logic          req0_valid, req0_write, req1_valid, req1_write;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [15:0]   req0_wdata, req1_wdata;
    logic [1:0]    req0_be, req1_be;
    logic          req0_gnt, req0_rvalid, req1_gnt, req1_rvalid;
    logic [15:0]   req0_rdata, req1_rdata;
`ifdef DIRCC_MEM_ARB_BOUNDS_EN
    logic          req0_rerr, req1_rerr;
`endif
    logic          mem_chipselect2, mem_write2, mem_clken2;
    logic [AW-1:0] mem_address2;
    logic [15:0]   mem_writedata2;
    logic [1:0]    mem_byteenable2;
    logic [15:0]   mem_readdata2;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    dircc_node_mem_port2_arbiter #(.DEPTH(10000), .AW(AW)) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_be(req0_be), .req0_gnt(req0_gnt),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
`ifdef DIRCC_MEM_ARB_BOUNDS_EN
        .req0_rerr(req0_rerr),
`endif
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_gnt(req1_gnt),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
`ifdef DIRCC_MEM_ARB_BOUNDS_EN
        .req1_rerr(req1_rerr),
`endif
        .mem_chipselect2(mem_chipselect2), .mem_write2(mem_write2),
        .mem_address2(mem_address2), .mem_writedata2(mem_writedata2),
        .mem_byteenable2(mem_byteenable2), .mem_clken2(mem_clken2),
        .mem_readdata2(mem_readdata2), .err_count(err_count)
    );

    // Cycle counter used to check response latency.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // s2 RAM model: registered read, byte-enabled write, preloaded on cycle 0.
    logic [15:0] ram [0:16383];
    logic [15:0] ram_q;
    always @(posedge clk) begin
        if (cyc == 0) begin
            ram[14'h0010] <= 16'h1111;
            ram[14'h0020] <= 16'h2222;
        end else if (mem_chipselect2) begin
            if (mem_write2) begin
                if (mem_byteenable2[0]) ram[mem_address2][7:0]  <= mem_writedata2[7:0];
                if (mem_byteenable2[1]) ram[mem_address2][15:8] <= mem_writedata2[15:8];
            end else begin
                ram_q <= ram[mem_address2];
            end
        end
    end
    assign mem_readdata2 = ram_q;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic        err;
        int          at;
    } rsp_t;
    rsp_t q[$];
    rsp_t m_e;

    // Monitor: every rvalid must match the oldest expected response.
    always @(negedge clk) begin
        if (req0_rvalid || req1_rvalid) begin
            if (q.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, req1_rvalid, req0_rvalid}, 32'd0);
            end else begin
                m_e = q.pop_front();
                chk("rsp_rvalid0", req0_rvalid, !m_e.id);
                chk("rsp_rvalid1", req1_rvalid, m_e.id);
                chk("rsp_rdata", m_e.id ? req1_rdata : req0_rdata, m_e.data);
                chk("rsp_other_rdata", m_e.id ? req0_rdata : req1_rdata, 0);
                chk("rsp_cycle", cyc, m_e.at);
`ifdef DIRCC_MEM_ARB_BOUNDS_EN
                chk("rsp_rerr", m_e.id ? req1_rerr : req0_rerr, m_e.err);
                chk("rsp_other_rerr", m_e.id ? req0_rerr : req1_rerr, 0);
`endif
            end
        end
    end

    logic [AW-1:0] last_addr = '0;

    // One cycle of stimulus plus the expected combinational grant/strobe.
    task automatic step(
        input logic v0, input logic w0, input logic [AW-1:0] a0,
        input logic [15:0] d0, input logic [1:0] b0,
        input logic v1, input logic w1, input logic [AW-1:0] a1,
        input logic [15:0] d1, input logic [1:0] b1,
        input logic frz, input logic rs,
        input logic eg0, input logic eg1, input logic ecs,
        input logic push, input logic [15:0] erd, input logic eerr);
        rsp_t r;
        logic          ww;
        logic [AW-1:0] wa;
        logic [15:0]   wd;
        logic [1:0]    wb;
        @(posedge clk);
        #1;
        req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0; req0_be = b0;
        req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1; req1_be = b1;
        freeze = frz; reset = rs;
        @(negedge clk);
        chk("gnt0", req0_gnt, eg0);
        chk("gnt1", req1_gnt, eg1);
        chk("chipselect2", mem_chipselect2, ecs);
        chk("clken2", mem_clken2, 1);
        if (eg0 || eg1) begin
            ww = eg1 ? w1 : w0;
            wa = eg1 ? a1 : a0;
            wd = eg1 ? d1 : d0;
            wb = eg1 ? b1 : b0;
            chk("address2", mem_address2, wa);
            chk("write2", mem_write2, ecs && ww);
            if (ww && ecs) begin
                chk("writedata2", mem_writedata2, wd);
                chk("byteenable2", mem_byteenable2, wb);
            end
            last_addr = wa;
            if (push) begin
                r.id = eg1; r.data = erd; r.err = eerr; r.at = cyc + 1;
                q.push_back(r);
            end
        end else begin
            chk("write2_idle", mem_write2, 0);
            if (!rs) chk("address2_hold", mem_address2, last_addr);
        end
        if (rs) last_addr = '0;
    endtask

    initial begin
        reset = 1'b1; freeze = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0; req0_be = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0; req1_be = '0;

        // Reset with both requesters valid: no grants, no strobe.
        repeat (3) begin
            step(1,0,14'h0010,0,2'b11, 1,0,14'h0020,0,2'b11, 0,1, 0,0,0, 0,0,0);
            chk("err_count_reset", err_count, 0);
        end

        // Contention: strict alternation starting with requester 0.
        step(1,0,14'h0010,0,2'b11, 1,0,14'h0020,0,2'b11, 0,0, 1,0,1, 1,16'h1111,0);
        step(1,0,14'h0010,0,2'b11, 1,0,14'h0020,0,2'b11, 0,0, 0,1,1, 1,16'h2222,0);
        step(1,0,14'h0010,0,2'b11, 1,0,14'h0020,0,2'b11, 0,0, 1,0,1, 1,16'h1111,0);
        step(1,0,14'h0010,0,2'b11, 1,0,14'h0020,0,2'b11, 0,0, 0,1,1, 1,16'h2222,0);

        // Full write, read-back, partial write of the high byte, read-back.
        step(1,1,14'h0100,16'hA5C3,2'b11, 0,0,14'h0000,0,2'b00, 0,0, 1,0,1, 0,0,0);
        step(0,0,14'h0000,0,2'b00, 1,0,14'h0100,0,2'b11, 0,0, 0,1,1, 1,16'hA5C3,0);
        step(1,1,14'h0100,16'h1200,2'b10, 0,0,14'h0000,0,2'b00, 0,0, 1,0,1, 0,0,0);
        step(0,0,14'h0000,0,2'b00, 1,0,14'h0100,0,2'b11, 0,0, 0,1,1, 1,16'h12C3,0);

        // Freeze right after a read grant: response still returns, no grants.
        step(1,0,14'h0010,0,2'b11, 1,0,14'h0020,0,2'b11, 0,0, 1,0,1, 1,16'h1111,0);
        step(1,0,14'h0010,0,2'b11, 1,0,14'h0020,0,2'b11, 1,0, 0,0,0, 0,0,0);
        step(1,0,14'h0010,0,2'b11, 1,0,14'h0020,0,2'b11, 1,0, 0,0,0, 0,0,0);
        step(1,0,14'h0010,0,2'b11, 1,0,14'h0020,0,2'b11, 0,0, 0,1,1, 1,16'h2222,0);
        step(0,0,14'h0000,0,2'b00, 0,0,14'h0000,0,2'b00, 0,0, 0,0,0, 0,0,0);

        // Reset right after a read grant (prio left at 1): read discarded.
        step(1,0,14'h0010,0,2'b11, 0,0,14'h0000,0,2'b00, 0,0, 1,0,1, 0,0,0);
        step(0,0,14'h0000,0,2'b00, 0,0,14'h0000,0,2'b00, 0,1, 0,0,0, 0,0,0);
        chk("rvalid0_in_reset", req0_rvalid, 0);
        chk("rvalid1_in_reset", req1_rvalid, 0);
        step(0,0,14'h0000,0,2'b00, 0,0,14'h0000,0,2'b00, 0,1, 0,0,0, 0,0,0);
        step(1,0,14'h0010,0,2'b11, 1,0,14'h0020,0,2'b11, 0,0, 1,0,1, 1,16'h1111,0);

`ifdef DIRCC_MEM_ARB_BOUNDS_EN
        // Out-of-range read then write: consumed, not strobed, counted.
        step(0,0,14'h0000,0,2'b00, 1,0,14'd10000,0,2'b11, 0,0, 0,1,0, 1,16'h0000,1);
        step(0,0,14'h0000,0,2'b00, 1,1,14'd16383,16'hBEEF,2'b11, 0,0, 0,1,0, 0,0,0);
        step(0,0,14'h0000,0,2'b00, 0,0,14'h0000,0,2'b00, 0,0, 0,0,0, 0,0,0);
        chk("err_count_2", err_count, 2);
        repeat (300) begin
            step(0,0,14'h0000,0,2'b00, 1,1,14'd16383,16'hBEEF,2'b11, 0,0, 0,1,0, 0,0,0);
        end
        step(0,0,14'h0000,0,2'b00, 0,0,14'h0000,0,2'b00, 0,0, 0,0,0, 0,0,0);
        chk("err_count_sat", err_count, 255);
`else
        step(0,0,14'h0000,0,2'b00, 0,0,14'h0000,0,2'b00, 0,0, 0,0,0, 0,0,0);
        chk("err_count_tied", err_count, 0);
`endif

        repeat (3) step(0,0,14'h0000,0,2'b00, 0,0,14'h0000,0,2'b00, 0,0, 0,0,0, 0,0,0);
        chk("rsp_queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
